main_fsm: RTL and testbench

// Multicycle RISC-V control FSM (Moore) for the RV32I subset lw/sw/R-type/I-type ALU/jal/beq.

---
 rtl/main_fsm_if.sv | 35 +++
 rtl/main_fsm.sv | 194 +++++++++++++++++++
 tb/tb_main_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_fsm_if.sv
// Controller <-> datapath bundle for the multicycle RV32I control FSM.
//   op, zero        : instruction opcode and ALU zero flag into the controller
//   adr_src .. pc_write : datapath enables and mux selects out of the controller
//   illegal, state, retired : status/debug outputs
// Modport master is the controller side, slave is the datapath side.
interface main_fsm_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [6:0]       op;
  logic             zero;
  logic             adr_src;
  logic             ir_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_write;
  logic             pc_write;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, zero,
    output adr_src, ir_write, alu_src_a, alu_src_b, result_src, alu_op,
           reg_write, mem_write, pc_write, illegal, state, retired
  );

  modport slave (
    output op, zero,
    input  adr_src, ir_write, alu_src_a, alu_src_b, result_src, alu_op,
           reg_write, mem_write, pc_write, illegal, state, retired
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM (Moore) for lw/sw/R-type/I-type/jal/beq.
// Sequences datapath enables and mux selects from Fetch through Writeback and
// produces alu_op for the ALU decoder.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : main_fsm_if.master (op/zero in; control, illegal, state, retired out)
// Parameters: ILLEGAL_TRAP (1: unknown op -> sticky ERROR, 0: unknown op -> FETCH),
//             CNT_W (retired-instruction counter width).
module main_fsm #(
  parameter int unsigned ILLEGAL_TRAP = 0,
  parameter int unsigned CNT_W        = 32
) (
  input logic         clk,
  input logic         reset_n,
  main_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StError    = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Outputs are decoded from the next state and registered with it, so they
  // stay glitch-free and line up exactly with state_q.
  logic       adr_src_q, adr_src_d;
  logic       ir_write_q, ir_write_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] result_src_q, result_src_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       pc_update_q, pc_update_d;
  logic       branch_q, branch_d;
  logic       illegal_q, illegal_d;

  // Next-state and retired counter
  always_comb begin
    state_d   = StFetch;
    retired_d = retired_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default:         state_d = (ILLEGAL_TRAP != 0) ? StError : StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: state_d = StMemWb;
      StExecR, StExecI, StJal: state_d = StAluWb;
      StMemWb, StMemWrite, StAluWb, StBeq: begin
        state_d   = StFetch;
        retired_d = retired_q + CNT_W'(1);
      end
      StError: state_d = StError;
      default: state_d = StFetch;
    endcase
  end

  // Moore output decode of the state about to be entered
  always_comb begin
    adr_src_d    = 1'b0;
    ir_write_d   = 1'b0;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    result_src_d = 2'b00;
    alu_op_d     = 2'b00;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    pc_update_d  = 1'b0;
    branch_d     = 1'b0;
    illegal_d    = 1'b0;
    unique case (state_d)
      StFetch: begin
        ir_write_d   = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
        pc_update_d  = 1'b1;
      end
      StDecode: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
      end
      StMemAdr: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
      end
      StMemRead: adr_src_d = 1'b1;
      StMemWb: begin
        result_src_d = 2'b01;
        reg_write_d  = 1'b1;
      end
      StMemWrite: begin
        adr_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      StExecR: begin
        alu_src_a_d = 2'b10;
        alu_op_d    = 2'b10;
      end
      StExecI: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        alu_op_d    = 2'b10;
      end
      StAluWb: reg_write_d = 1'b1;
      StJal: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        pc_update_d = 1'b1;
      end
      StBeq: begin
        alu_src_a_d = 2'b10;
        alu_op_d    = 2'b01;
        branch_d    = 1'b1;
      end
      StError: illegal_d = 1'b1;
      default: ;
    endcase
  end

  // Reset values match the FETCH decode so outputs are consistent with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      retired_q    <= '0;
      adr_src_q    <= 1'b0;
      ir_write_q   <= 1'b1;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      result_src_q <= 2'b10;
      alu_op_q     <= 2'b00;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      pc_update_q  <= 1'b1;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      retired_q    <= retired_d;
      adr_src_q    <= adr_src_d;
      ir_write_q   <= ir_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      result_src_q <= result_src_d;
      alu_op_q     <= alu_op_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      pc_update_q  <= pc_update_d;
      branch_q     <= branch_d;
      illegal_q    <= illegal_d;
    end
  end

  // Write strobes are gated by reset_n so nothing is written while in reset.
  assign bus.adr_src    = adr_src_q;
  assign bus.ir_write   = ir_write_q & reset_n;
  assign bus.alu_src_a  = alu_src_a_q;
  assign bus.alu_src_b  = alu_src_b_q;
  assign bus.result_src = result_src_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.reg_write  = reg_write_q & reset_n;
  assign bus.mem_write  = mem_write_q & reset_n;
  assign bus.pc_write   = (pc_update_q | (branch_q & bus.zero)) & reset_n;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_main_fsm.sv
module tb_main_fsm;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  main_fsm_if #(.CNT_W(32)) bus_a ();
  main_fsm_if #(.CNT_W(4))  bus_b ();

  main_fsm #(.ILLEGAL_TRAP(1), .CNT_W(32)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.master)
  );

  main_fsm #(.ILLEGAL_TRAP(0), .CNT_W(4)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.master)
  );

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpBad   = 7'b1111111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, release on a falling edge; FETCH is then visible mid-cycle.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus_a.state !== 4'd0) begin
      bad++; $display("FAIL reset_state got=%0d want=0", bus_a.state);
    end
    total++;
    if (bus_a.retired !== 32'd0) begin
      bad++; $display("FAIL reset_retired got=%0d want=0", bus_a.retired);
    end
    total++;
    if (bus_a.ir_write !== 1'b0 || bus_a.pc_write !== 1'b0) begin
      bad++; $display("FAIL reset_gating ir_write=%b pc_write=%b want 0 0",
                      bus_a.ir_write, bus_a.pc_write);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (bus_a.ir_write !== 1'b1 || bus_a.pc_write !== 1'b1 || bus_a.alu_src_b !== 2'b10 ||
        bus_a.result_src !== 2'b10 || bus_a.alu_src_a !== 2'b00 || bus_a.alu_op !== 2'b00) begin
      bad++; $display("FAIL fetch_outputs ir=%b pcw=%b a=%b b=%b rs=%b aop=%b want 1 1 00 10 10 00",
                      bus_a.ir_write, bus_a.pc_write, bus_a.alu_src_a, bus_a.alu_src_b,
                      bus_a.result_src, bus_a.alu_op);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    bus_a.op = OpLoad;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus_a.state !== exp_st[i]) begin
        bad++; $display("FAIL lw_state step=%0d got=%0d want=%0d", i, bus_a.state, exp_st[i]);
      end
      total++;
      if (bus_a.reg_write !== (exp_st[i] == 4'd4)) begin
        bad++; $display("FAIL lw_reg_write step=%0d got=%b", i, bus_a.reg_write);
      end
      if (exp_st[i] == 4'd1) begin
        total++;
        if (bus_a.alu_src_a !== 2'b01 || bus_a.alu_src_b !== 2'b01) begin
          bad++; $display("FAIL decode_mux a=%b b=%b want 01 01", bus_a.alu_src_a, bus_a.alu_src_b);
        end
      end
      if (exp_st[i] == 4'd2) begin
        total++;
        if (bus_a.alu_src_a !== 2'b10 || bus_a.alu_src_b !== 2'b01) begin
          bad++; $display("FAIL memadr_mux a=%b b=%b want 10 01", bus_a.alu_src_a, bus_a.alu_src_b);
        end
      end
      if (exp_st[i] == 4'd3) begin
        total++;
        if (bus_a.adr_src !== 1'b1) begin
          bad++; $display("FAIL memread_adr got=%b want=1", bus_a.adr_src);
        end
      end
      if (exp_st[i] == 4'd4) begin
        total++;
        if (bus_a.result_src !== 2'b01) begin
          bad++; $display("FAIL memwb_result_src got=%b want=01", bus_a.result_src);
        end
      end
    end
    total++;
    if (bus_a.retired !== 32'd1) begin
      bad++; $display("FAIL lw_retired got=%0d want=1", bus_a.retired);
    end
  endtask

  task automatic test_store();
    logic [3:0] exp_st [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
    int writes = 0;
    bus_a.op = OpStore;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus_a.state !== exp_st[i]) begin
        bad++; $display("FAIL sw_state step=%0d got=%0d want=%0d", i, bus_a.state, exp_st[i]);
      end
      if (bus_a.mem_write === 1'b1) writes++;
      if (exp_st[i] == 4'd5) begin
        total++;
        if (bus_a.adr_src !== 1'b1 || bus_a.mem_write !== 1'b1) begin
          bad++; $display("FAIL memwrite_out adr_src=%b mem_write=%b want 1 1",
                          bus_a.adr_src, bus_a.mem_write);
        end
      end
    end
    total++;
    if (writes != 1) begin
      bad++; $display("FAIL sw_write_cycles got=%0d want=1", writes);
    end
    total++;
    if (bus_a.retired !== 32'd2) begin
      bad++; $display("FAIL sw_retired got=%0d want=2", bus_a.retired);
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_st [3] = '{4'd1, 4'd10, 4'd0};
    for (int pass = 0; pass < 2; pass++) begin
      bus_a.op   = OpBeq;
      bus_a.zero = (pass == 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        total++;
        if (bus_a.state !== exp_st[i]) begin
          bad++; $display("FAIL beq_state pass=%0d step=%0d got=%0d want=%0d",
                          pass, i, bus_a.state, exp_st[i]);
        end
        if (exp_st[i] == 4'd10) begin
          total++;
          if (bus_a.pc_write !== (pass == 0) || bus_a.alu_op !== 2'b01) begin
            bad++; $display("FAIL beq_out pass=%0d pc_write=%b alu_op=%b want %b 01",
                            pass, bus_a.pc_write, bus_a.alu_op, (pass == 0));
          end
          // zero is used combinationally in BEQ
          bus_a.zero = ~bus_a.zero;
          #1;
          total++;
          if (bus_a.pc_write !== bus_a.zero) begin
            bad++; $display("FAIL beq_zero_comb pc_write=%b want=%b", bus_a.pc_write, bus_a.zero);
          end
        end
      end
    end
    bus_a.zero = 1'b0;
    total++;
    if (bus_a.retired !== 32'd4) begin
      bad++; $display("FAIL beq_retired got=%0d want=4", bus_a.retired);
    end
  endtask

  task automatic test_alu();
    logic [3:0] exp_r [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
    logic [3:0] exp_i [4] = '{4'd1, 4'd8, 4'd7, 4'd0};
    logic [3:0] want;
    for (int k = 0; k < 2; k++) begin
      bus_a.op = (k == 0) ? OpR : OpI;
      for (int i = 0; i < 4; i++) begin
        tick();
        want = (k == 0) ? exp_r[i] : exp_i[i];
        total++;
        if (bus_a.state !== want) begin
          bad++; $display("FAIL alu_state k=%0d step=%0d got=%0d want=%0d",
                          k, i, bus_a.state, want);
        end
        if (i == 1) begin
          total++;
          if (bus_a.alu_op !== 2'b10 || bus_a.alu_src_a !== 2'b10 ||
              bus_a.alu_src_b !== ((k == 0) ? 2'b00 : 2'b01)) begin
            bad++; $display("FAIL exec_out k=%0d alu_op=%b a=%b b=%b",
                            k, bus_a.alu_op, bus_a.alu_src_a, bus_a.alu_src_b);
          end
        end
        if (i == 2) begin
          total++;
          if (bus_a.reg_write !== 1'b1) begin
            bad++; $display("FAIL aluwb_reg_write k=%0d got=%b want=1", k, bus_a.reg_write);
          end
        end
      end
      total++;
      if (bus_a.retired !== 32'(5 + k)) begin
        bad++; $display("FAIL alu_retired k=%0d got=%0d want=%0d", k, bus_a.retired, 5 + k);
      end
    end
  endtask

  task automatic test_jal();
    logic [3:0] exp_st [4] = '{4'd1, 4'd9, 4'd7, 4'd0};
    bus_a.op = OpJal;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus_a.state !== exp_st[i]) begin
        bad++; $display("FAIL jal_state step=%0d got=%0d want=%0d", i, bus_a.state, exp_st[i]);
      end
      if (exp_st[i] == 4'd9) begin
        total++;
        if (bus_a.pc_write !== 1'b1 || bus_a.alu_src_a !== 2'b01 || bus_a.alu_src_b !== 2'b10) begin
          bad++; $display("FAIL jal_out pc_write=%b a=%b b=%b want 1 01 10",
                          bus_a.pc_write, bus_a.alu_src_a, bus_a.alu_src_b);
        end
      end
    end
    total++;
    if (bus_a.retired !== 32'd7) begin
      bad++; $display("FAIL jal_retired got=%0d want=7", bus_a.retired);
    end
  endtask

  task automatic test_illegal_trap();
    bus_a.op = OpBad;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus_a.state !== 4'd15 || bus_a.illegal !== 1'b1) begin
        bad++; $display("FAIL trap_hold cycle=%0d state=%0d illegal=%b want 15 1",
                        i, bus_a.state, bus_a.illegal);
      end
      tick();
    end
    total++;
    if (bus_a.retired !== 32'd7) begin
      bad++; $display("FAIL trap_retired got=%0d want=7", bus_a.retired);
    end
  endtask

  task automatic test_illegal_notrap();
    do_reset();
    bus_b.op = OpBad;
    tick();
    total++;
    if (bus_b.state !== 4'd1) begin
      bad++; $display("FAIL notrap_decode got=%0d want=1", bus_b.state);
    end
    tick();
    total++;
    if (bus_b.state !== 4'd0 || bus_b.illegal !== 1'b0 || bus_b.retired !== 4'd0) begin
      bad++; $display("FAIL notrap_fetch state=%0d illegal=%b retired=%0d want 0 0 0",
                      bus_b.state, bus_b.illegal, bus_b.retired);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    bus_a.op = OpStore;
    tick();
    tick();
    tick();
    total++;
    if (bus_a.state !== 4'd5 || bus_a.mem_write !== 1'b1) begin
      bad++; $display("FAIL pre_abort state=%0d mem_write=%b want 5 1",
                      bus_a.state, bus_a.mem_write);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus_a.state !== 4'd0 || bus_a.mem_write !== 1'b0) begin
      bad++; $display("FAIL abort state=%0d mem_write=%b want 0 0", bus_a.state, bus_a.mem_write);
    end
    do_reset();
    total++;
    if (bus_a.retired !== 32'd0) begin
      bad++; $display("FAIL abort_retired got=%0d want=0", bus_a.retired);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus_b.op   = OpBeq;
    bus_b.zero = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      repeat (3) tick();
      total++;
      if (bus_b.retired !== 4'(n % 16)) begin
        bad++; $display("FAIL wrap_retired n=%0d got=%0d want=%0d", n, bus_b.retired, n % 16);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    bus_a.op   = OpLoad;
    bus_a.zero = 1'b0;
    bus_b.op   = OpBeq;
    bus_b.zero = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_beq();
    test_alu();
    test_jal();
    test_illegal_trap();
    test_illegal_notrap();
    test_reset_mid_store();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
